// File: rtl/gpio_controller.sv
// GPIO controller: per-pin direction/output registers, synchronised inputs with
// edge detection, W1C interrupt-pending latch and a single-cycle-response bus slave.
module gpio_controller #(
    parameter int WIDTH = 48,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_req,
    input  logic             bus_we,
    input  logic [5:0]       bus_addr,
    input  logic [XLEN-1:0]  bus_wdata,
    output logic [XLEN-1:0]  bus_rdata,
    output logic             bus_rvalid,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam int PW = 64;

    localparam logic [2:0] REG_DIR     = 3'd0;
    localparam logic [2:0] REG_OUT     = 3'd1;
    localparam logic [2:0] REG_IN      = 3'd2;
    localparam logic [2:0] REG_IE      = 3'd3;
    localparam logic [2:0] REG_POL     = 3'd4;
    localparam logic [2:0] REG_PEND    = 3'd5;
    localparam logic [2:0] REG_OUT_SET = 3'd6;
    localparam logic [2:0] REG_OUT_CLR = 3'd7;

    // Bits at or above WIDTH never hold state, so every write is masked with this.
    localparam logic [PW-1:0] VALID_MASK = {PW{1'b1}} >> (PW - WIDTH);

    function automatic logic [31:0] bank_sel(input logic [PW-1:0] v, input logic bank);
        return bank ? v[63:32] : v[31:0];
    endfunction

    function automatic logic [PW-1:0] merge(input logic [PW-1:0] old_v,
                                            input logic [PW-1:0] bits,
                                            input logic [PW-1:0] mask);
        return (old_v & ~mask) | (bits & mask);
    endfunction

    logic [PW-1:0] r_dir;
    logic [PW-1:0] r_out;
    logic [PW-1:0] r_ie;
    logic [PW-1:0] r_pol;
    logic [PW-1:0] r_pend;
    logic [PW-1:0] r_s1;
    logic [PW-1:0] r_s2;
    logic [PW-1:0] r_s3;
    logic [1:0]    r_warm;
    logic          r_irq;
    logic          r_rvalid;
    logic [31:0]   r_rdata;

    logic          w_rd;
    logic          w_wr;
    logic [2:0]    w_reg;
    logic          w_bank;
    logic [7:0]    w_wsel;
    logic [PW-1:0] w_in64;
    logic [PW-1:0] w_wmask;
    logic [PW-1:0] w_wdata;
    logic [PW-1:0] w_wbits;
    logic          w_warm_done;
    logic [PW-1:0] w_rise;
    logic [PW-1:0] w_fall;
    logic [PW-1:0] w_edge;
    logic [PW-1:0] w_out_next;
    logic [PW-1:0] w_pend_next;
    logic [PW-1:0] w_rsel;
    logic          w_unused;

    assign w_unused = &{1'b0, bus_addr[1:0]};

    assign w_rd    = bus_req & ~bus_we;
    assign w_wr    = bus_req & bus_we;
    assign w_reg   = bus_addr[5:3];
    assign w_bank  = bus_addr[2];
    assign w_wsel  = w_wr ? (8'd1 << w_reg) : 8'd0;
    assign w_in64  = PW'(gpio_in);

    assign w_wmask = VALID_MASK & (w_bank ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF});
    assign w_wdata = w_bank ? {bus_wdata, 32'h0} : {32'h0, bus_wdata};
    assign w_wbits = w_wdata & w_wmask;

    // Edges are suppressed until the synchroniser has flushed its reset zeros.
    assign w_warm_done = (r_warm == 2'd3);
    assign w_rise      = r_s2 & ~r_s3;
    assign w_fall      = ~r_s2 & r_s3;
    assign w_edge      = w_warm_done ? ((r_pol & w_rise) | (~r_pol & w_fall)) : '0;

    // Only one register is addressed per cycle; the chain just encodes precedence.
    always_comb begin
        w_out_next = r_out;
        if (w_wsel[REG_OUT]) begin
            w_out_next = merge(r_out, w_wbits, w_wmask);
        end else if (w_wsel[REG_OUT_SET]) begin
            w_out_next = r_out | w_wbits;
        end else if (w_wsel[REG_OUT_CLR]) begin
            w_out_next = r_out & ~w_wbits;
        end
    end

    // A new edge wins over a simultaneous W1C of the same bit.
    assign w_pend_next = (r_pend & ~(w_wsel[REG_PEND] ? w_wbits : '0)) | w_edge;

    always_comb begin
        w_rsel = '0;
        case (w_reg)
            REG_DIR:  w_rsel = r_dir;
            REG_OUT:  w_rsel = r_out;
            REG_IN:   w_rsel = r_s2;
            REG_IE:   w_rsel = r_ie;
            REG_POL:  w_rsel = r_pol;
            REG_PEND: w_rsel = r_pend;
            default:  w_rsel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir  <= '0;
            r_out  <= '0;
            r_ie   <= '0;
            r_pol  <= '0;
            r_pend <= '0;
        end else begin
            r_out  <= w_out_next;
            r_pend <= w_pend_next;
            if (w_wsel[REG_DIR]) r_dir <= merge(r_dir, w_wbits, w_wmask);
            if (w_wsel[REG_IE])  r_ie  <= merge(r_ie, w_wbits, w_wmask);
            if (w_wsel[REG_POL]) r_pol <= merge(r_pol, w_wbits, w_wmask);
        end
    end

    // Two-flop synchroniser for the asynchronous pins, then the edge-history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_warm <= 2'd0;
        end else begin
            r_s1 <= w_in64;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (!w_warm_done) r_warm <= r_warm + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_irq    <= |(r_pend & r_ie);
            r_rvalid <= w_rd;
            r_rdata  <= w_rd ? bank_sel(w_rsel, w_bank) : 32'h0;
        end
    end

    assign gpio_out   = r_out[WIDTH-1:0];
    assign gpio_oe    = r_dir[WIDTH-1:0];
    assign irq        = r_irq;
    assign bus_rvalid = r_rvalid;
    assign bus_rdata  = r_rdata;

endmodule

// File: tb/tb_gpio_controller.sv
// Bench for gpio_controller: directed scenarios plus randomized bus/pin traffic
// compared cycle by cycle against a register-map reference model.
module tb_gpio_controller;

    localparam int WIDTH = 48;
    localparam logic [63:0] VALID = (64'd1 << WIDTH) - 64'd1;

    logic             clk;
    logic             rst_n;
    logic             bus_req;
    logic             bus_we;
    logic [5:0]       bus_addr;
    logic [31:0]      bus_wdata;
    logic [31:0]      bus_rdata;
    logic             bus_rvalid;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [63:0] m_dir, m_out, m_ie, m_pol, m_pend;
    logic        m_irq, m_rvalid;
    logic [31:0] m_rdata;
    logic [63:0] m_hist [3];   // pin values sampled 1, 2 and 3 clock edges ago
    int          m_edges;      // clock edges seen since reset release (saturating)

    gpio_controller #(.WIDTH(WIDTH), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_dir = 0; m_out = 0; m_ie = 0; m_pol = 0; m_pend = 0;
        m_irq = 0; m_rvalid = 0; m_rdata = 0;
        for (int i = 0; i < 3; i++) m_hist[i] = 0;
        m_edges = 0;
    endtask

    function automatic logic [31:0] reg_view(input int rg, input int bank);
        logic [63:0] v;
        case (rg)
            0: v = m_dir;
            1: v = m_out;
            2: v = m_hist[1];
            3: v = m_ie;
            4: v = m_pol;
            5: v = m_pend;
            default: v = 64'd0;
        endcase
        return 32'(v >> (32 * bank));
    endfunction

    // One clock edge of the register map, using the inputs present at that edge.
    task automatic model_step();
        logic [63:0] rise, fall, edges, mask, bits, w1c;
        int rg, bank;
        rise  = m_hist[1] & ~m_hist[2];
        fall  = ~m_hist[1] & m_hist[2];
        edges = (m_edges >= 3) ? (((m_pol & rise) | (~m_pol & fall)) & VALID) : 64'd0;
        rg    = int'(bus_addr[5:3]);
        bank  = int'(bus_addr[2]);
        mask  = VALID & (64'hFFFF_FFFF << (32 * bank));
        bits  = (64'(bus_wdata) << (32 * bank)) & mask;
        w1c   = 64'd0;
        m_irq    = |(m_pend & m_ie);
        m_rvalid = bus_req && !bus_we;
        m_rdata  = m_rvalid ? reg_view(rg, bank) : 32'd0;
        if (bus_req && bus_we) begin
            case (rg)
                0: m_dir = (m_dir & ~mask) | bits;
                1: m_out = (m_out & ~mask) | bits;
                3: m_ie  = (m_ie & ~mask) | bits;
                4: m_pol = (m_pol & ~mask) | bits;
                5: w1c   = bits;
                6: m_out = m_out | bits;
                7: m_out = m_out & ~bits;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~w1c) | edges;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = 64'(gpio_in);
        if (m_edges < 3) m_edges++;
    endtask

    task automatic compare_outputs();
        check("rvalid",   64'(bus_rvalid), 64'(m_rvalid));
        check("rdata",    64'(bus_rdata),  64'(m_rdata));
        check("gpio_out", 64'(gpio_out),   m_out & VALID);
        check("gpio_oe",  64'(gpio_oe),    m_dir & VALID);
        check("irq",      64'(irq),        64'(m_irq));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_wr(input logic [2:0] rg, input logic bank, input logic [31:0] d);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = {rg, bank, 2'b00}; bus_wdata = d;
        cycle();
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] rg, input logic bank, output logic [31:0] d);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = {rg, bank, 2'b00};
        cycle();
        d = bus_rdata;
        bus_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b1;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 6'd0;
        bus_wdata = 32'd0;
        gpio_in   = '1;
        model_reset();
        #2;

        // Reset with all pins high, no false edges afterwards
        apply_reset();
        check("rst_rvalid", 64'(bus_rvalid), 64'd0);
        check("rst_rdata",  64'(bus_rdata),  64'd0);
        check("rst_irq",    64'(irq),        64'd0);
        idle(10);
        check("t1_irq", 64'(irq), 64'd0);
        bus_rd(3'd5, 1'b0, d); check("t1_pend_b0", 64'(d), 64'h0);
        bus_rd(3'd5, 1'b1, d); check("t1_pend_b1", 64'(d), 64'h0);
        bus_rd(3'd2, 1'b0, d); check("t1_in_b0",   64'(d), 64'hFFFF_FFFF);
        bus_rd(3'd2, 1'b1, d); check("t1_in_b1",   64'(d), 64'h0000_FFFF);

        // Bank 1 writes clip to the implemented pins
        bus_wr(3'd0, 1'b1, 32'hFFFF_FFFF);
        bus_wr(3'd1, 1'b1, 32'h1234_5678);
        check("t2_oe_hi",  64'(gpio_oe[47:32]),  64'hFFFF);
        check("t2_out_hi", 64'(gpio_out[47:32]), 64'h5678);
        bus_rd(3'd0, 1'b1, d); check("t2_dir_b1", 64'(d), 64'h0000_FFFF);
        bus_rd(3'd1, 1'b1, d); check("t2_out_b1", 64'(d), 64'h0000_5678);

        // OUT, OUT_SET, OUT_CLR
        bus_wr(3'd1, 1'b0, 32'h0000_000F);
        bus_wr(3'd6, 1'b0, 32'h0000_00F0);
        bus_wr(3'd7, 1'b0, 32'h0000_0003);
        check("t3_out_lo", 64'(gpio_out[7:0]), 64'hFC);
        bus_rd(3'd6, 1'b0, d); check("t3_set_rd", 64'(d), 64'h0);
        bus_rd(3'd7, 1'b0, d); check("t3_clr_rd", 64'(d), 64'h0);

        // Rising-edge interrupt on pin 5; pins 5/7/9 rising, others falling
        bus_wr(3'd4, 1'b1, 32'hFFFF_FFFF);
        bus_wr(3'd4, 1'b0, 32'hFFFF_FFFF);
        gpio_in = '0;
        idle(5);
        bus_wr(3'd4, 1'b0, 32'h0000_02A0);
        bus_rd(3'd5, 1'b0, d); check("t4_pend_clear_b0", 64'(d), 64'h0);
        bus_rd(3'd5, 1'b1, d); check("t4_pend_clear_b1", 64'(d), 64'h0);
        bus_wr(3'd3, 1'b0, 32'h0000_0020);
        gpio_in[5] = 1'b1;
        cycle();
        cycle();
        bus_rd(3'd5, 1'b0, d); check("t4_pend_e3_old", 64'(d), 64'h0);
        check("t4_irq_e3", 64'(irq), 64'd0);
        bus_rd(3'd5, 1'b0, d); check("t4_pend_set", 64'(d), 64'h20);
        check("t4_irq_e4", 64'(irq), 64'd1);
        bus_wr(3'd5, 1'b0, 32'h0000_0020);
        check("t4_irq_w1c_edge", 64'(irq), 64'd1);
        cycle();
        check("t4_irq_cleared", 64'(irq), 64'd0);
        gpio_in[5] = 1'b0;
        idle(5);
        bus_rd(3'd5, 1'b0, d); check("t4_fall_nopend", 64'(d), 64'h0);
        check("t4_fall_noirq", 64'(irq), 64'd0);

        // Edge and W1C on the same bit in the same cycle; pending without enable
        gpio_in[7] = 1'b1;
        cycle();
        cycle();
        bus_wr(3'd5, 1'b0, 32'h0000_0080);
        bus_rd(3'd5, 1'b0, d); check("t5_set_wins", 64'(d), 64'h80);
        gpio_in[9] = 1'b1;
        idle(5);
        bus_rd(3'd5, 1'b0, d); check("t5_pend_noie", 64'(d), 64'h280);
        check("t5_irq_noie", 64'(irq), 64'd0);

        // Back-to-back reads, then reset with a read in flight
        bus_wr(3'd0, 1'b0, 32'hA5A5_0F0F);
        bus_req = 1'b1; bus_we = 1'b0;
        bus_addr = {3'd0, 1'b0, 2'b00}; cycle();
        check("t6_rv_dir", 64'(bus_rvalid), 64'd1); check("t6_rd_dir", 64'(bus_rdata), 64'hA5A5_0F0F);
        bus_addr = {3'd1, 1'b0, 2'b00}; cycle();
        check("t6_rv_out", 64'(bus_rvalid), 64'd1); check("t6_rd_out", 64'(bus_rdata), 64'hFC);
        bus_addr = {3'd5, 1'b0, 2'b00}; cycle();
        check("t6_rv_pend", 64'(bus_rvalid), 64'd1); check("t6_rd_pend", 64'(bus_rdata), 64'h280);
        bus_addr = {3'd3, 1'b0, 2'b00}; cycle();
        bus_req = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_rvalid", 64'(bus_rvalid), 64'd0);
        check("t6_rst_rdata",  64'(bus_rdata),  64'd0);
        check("t6_rst_oe",     64'(gpio_oe),    64'd0);
        check("t6_rst_out",    64'(gpio_out),   64'd0);
        cycle();
        rst_n = 1'b1;
        bus_rd(3'd0, 1'b0, d); check("t6_dir_zero",  64'(d), 64'h0);
        bus_rd(3'd1, 1'b1, d); check("t6_out_zero",  64'(d), 64'h0);
        bus_rd(3'd3, 1'b0, d); check("t6_ie_zero",   64'(d), 64'h0);
        bus_rd(3'd4, 1'b0, d); check("t6_pol_zero",  64'(d), 64'h0);
        bus_rd(3'd5, 1'b0, d); check("t6_pend_zero", 64'(d), 64'h0);

        // Warm-up masks the rising edges seen right after reset release
        gpio_in = '1;
        apply_reset();
        bus_wr(3'd4, 1'b0, 32'hFFFF_FFFF);
        idle(5);
        bus_rd(3'd5, 1'b0, d); check("t7_warmup_pend", 64'(d), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_outputs();
                cycle();
                rst_n = 1'b1;
            end
            bus_req   = ($urandom_range(0, 1) == 1);
            bus_we    = ($urandom_range(0, 1) == 1);
            bus_addr  = 6'($urandom);
            bus_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            if ($urandom_range(0, 3) == 0)
                gpio_in = gpio_in ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            cycle();
        end
        bus_req = 1'b0;
        bus_we  = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
